se_core_arbiter: RTL and testbench
==================================

Name: se_core_arbiter

Overview:
- Round-robin arbiter that shares one secure-element core command interface (control/address/data, 64-bit each, plus end_op) between N_REQ requesters, e.g. the host bridge and an internal self-test/PUF sequencer.
- The winning requester owns the core until it releases it or a watchdog expires.
- The core is always left in the idle command (control = 0) between owners.
- Sits directly in front of the SE_QUBIP-style core, replacing the single direct host connection.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- DW, 64, width of control, address and data buses.
- TIMEOUT, 1024, watchdog limit in cycles; 0 disables the watchdog.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_req  in  N_REQ  per-requester ownership request (level).
- i_release  in  N_REQ  per-requester one-cycle release pulse; only the owner's bit is honoured.
- i_control_r  in  N_REQ*DW  packed control words; requester i occupies bits [i*DW +: DW].
- i_add_r  in  N_REQ*DW  packed address words.
- i_data_in_r  in  N_REQ*DW  packed write data.
- o_grant  out  N_REQ  registered one-hot owner indication.
- o_control  out  DW  control word to the core.
- o_add  out  DW  address to the core.
- o_data_in  out  DW  write data to the core.
- i_data_out  in  DW  read data from the core.
- i_end_op  in  1  core operation-complete strobe.
- o_data_out_r  out  DW  core read data, gated to the owner.
- o_end_op_r  out  N_REQ  end_op routed to the owner only.
- o_busy  out  1  high whenever state is not IDLE.
- o_timeout  out  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (i_rst = 0, asynchronous):
  - All outputs are 0 and the state is IDLE.
  - The round-robin pointer last = N_REQ-1, so requester 0 has highest priority first.
  - The watchdog counter is 0.
  - Reset asserted mid-ownership drops the grant immediately; there is no flush cycle.
- IDLE:
  - If any i_req bit is set, the winner is the first set bit scanning from last+1 upward, with wrap-around.
  - At the next edge: o_grant = onehot(winner), last = winner, state becomes OWNED.
  - Grant latency is 1 cycle from the first sampled request.
- OWNED:
  - o_control, o_add and o_data_in combinationally mux the owner's slices.
  - o_data_out_r = i_data_out.
  - o_end_op_r = i_end_op on the owner's bit, 0 elsewhere.
  - Non-owners see 0 on every output.
- Leaving OWNED (next edge goes to FLUSH):
  - i_release[owner] = 1, or
  - i_req[owner] = 0, or
  - watchdog expiry.
- FLUSH (exactly 1 cycle):
  - o_grant = 0; o_control, o_add and o_data_in = 0; o_end_op_r = 0.
  - Then returns to IDLE.
  - The earliest re-grant is therefore 2 edges after release is sampled.
- Release priority:
  - Release in the same cycle as i_end_op: the end_op is still forwarded to the owner in that cycle, then FLUSH.
  - Release or i_req pulses from non-owners are ignored.
- Watchdog:
  - The counter increments each OWNED cycle with o_control != 0 and i_end_op = 0.
  - It clears on i_end_op, on o_control = 0, and on entering OWNED.
  - When counter = TIMEOUT-1 and it would increment: o_timeout = 1 for that cycle, then FLUSH.
  - The counter saturates and never wraps.
  - With TIMEOUT = 0 the counter is held at 0 and o_timeout is never asserted.
- Fairness: the previous owner is lowest priority at the next arbitration, so a requester holding i_req high continuously cannot starve the others.
- Arithmetic: the counter width is clog2(TIMEOUT+1), minimum 1; the pointer is a modulo-N_REQ increment.

Test Plan:
- Reset, then i_req = 2'b01 with i_control_r slice0 = 3, i_add_r slice0 = 0, i_data_in_r slice0 = 8193:
  - o_grant = 01 one edge later; o_control = 3, o_add = 0, o_data_in = 8193.
  - i_end_op pulse produces o_end_op_r = 01.
- Both requesters high from reset:
  - Requester 0 is granted first.
  - After release[0]: 1 FLUSH cycle with o_control = 0, then o_grant = 10.
  - After release[1]: o_grant = 01 again (round-robin).
- Owner 0 with i_control_r slice0 = 1 and no end_op, TIMEOUT = 16:
  - o_timeout pulses once, 16 cycles after grant.
  - o_grant = 00 in the following FLUSH cycle, then requester 1 is granted if requesting.
- release[0] and i_end_op in the same cycle:
  - o_end_op_r = 01 in that cycle, then FLUSH; non-owner release[1] during ownership has no effect.
- i_rst driven low mid-ownership, off a clock edge:
  - o_grant, o_control and o_busy go to 0 immediately.
  - After i_rst returns high with both requesting, requester 0 is granted.
- TIMEOUT = 0 with control = 4 held for 5000 cycles: no o_timeout and the grant is retained.

Source files
------------

// File: rtl/se_core_arbiter.sv
// Round-robin owner arbiter for a shared secure-element core port.
// One requester owns the core at a time; a flush cycle separates owners.
module se_core_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DW      = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ-1:0]      i_release,
    input  logic [N_REQ*DW-1:0]   i_control_r,
    input  logic [N_REQ*DW-1:0]   i_add_r,
    input  logic [N_REQ*DW-1:0]   i_data_in_r,
    output logic [N_REQ-1:0]      o_grant,
    output logic [DW-1:0]         o_control,
    output logic [DW-1:0]         o_add,
    output logic [DW-1:0]         o_data_in,
    input  logic [DW-1:0]         i_data_out,
    input  logic                  i_end_op,
    output logic [DW-1:0]         o_data_out_r,
    output logic [N_REQ-1:0]      o_end_op_r,
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWNED,
        ST_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [LW-1:0]    last_q, last_d;
    logic [CW-1:0]    wd_q, wd_d;
    logic [LW-1:0]    winner, cand;
    logic             req_any, owned, wd_active, wd_hit, drop;

    // Pick the first requester after the previous owner, wrapping around.
    always_comb begin
        winner  = last_q;
        cand    = last_q;
        req_any = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = LW'((int'(last_q) + k) % N_REQ);
            if (!req_any && i_req[cand]) begin
                req_any = 1'b1;
                winner  = cand;
            end
        end
    end

    // Route the owner's command slices to the core; everyone else sees zero.
    always_comb begin
        o_control = '0;
        o_add     = '0;
        o_data_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owned && last_q == LW'(i)) begin
                o_control = i_control_r[i*DW +: DW];
                o_add     = i_add_r[i*DW +: DW];
                o_data_in = i_data_in_r[i*DW +: DW];
            end
        end
    end

    assign owned        = (state_q == ST_OWNED);
    assign o_grant      = grant_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_data_out_r = owned ? i_data_out : '0;
    assign o_end_op_r   = (owned && i_end_op) ? grant_q : '0;
    assign wd_active    = owned && (o_control != '0) && !i_end_op;
    assign wd_hit       = (TIMEOUT != 0) && wd_active && (wd_q == CNT_LAST);
    assign o_timeout    = wd_hit;
    assign drop         = i_release[last_q] || !i_req[last_q] || wd_hit;

    // Ownership FSM; a flush cycle may hand over straight to the next winner.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE, ST_FLUSH: begin
                if (req_any) begin
                    state_d = ST_OWNED;
                    grant_d = N_REQ'(1) << winner;
                    last_d  = winner;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            ST_OWNED: begin
                if (drop) begin
                    state_d = ST_FLUSH;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Watchdog counts busy cycles without completion and saturates.
    always_comb begin
        wd_d = '0;
        if (TIMEOUT != 0 && wd_active && !drop) begin
            wd_d = (wd_q == CNT_MAX) ? wd_q : wd_q + 1'b1;
        end
    end

    // State, owner pointer and watchdog registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LW'(N_REQ - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_se_core_arbiter.sv
// Directed bench for se_core_arbiter.
// Two instances: watchdog of 16 cycles and watchdog disabled.
module tb_se_core_arbiter;

    localparam int DW = 64;
    localparam int N  = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req, rel;
    logic [N*DW-1:0] ctl, add, din;
    logic [DW-1:0] dout;
    logic          eop;
    logic [N-1:0]  grant, eop_r;
    logic [DW-1:0] control, add_o, din_o, dout_r;
    logic          busy, to;

    logic [N-1:0]  b_req;
    logic [N*DW-1:0] b_ctl;
    logic [N-1:0]  b_grant, b_eop_r;
    logic [DW-1:0] b_control, b_add_o, b_din_o, b_dout_r;
    logic          b_busy, b_to;

    int checks;
    int fails;

    se_core_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req(req), .i_release(rel),
        .i_control_r(ctl), .i_add_r(add), .i_data_in_r(din),
        .o_grant(grant), .o_control(control),
        .o_add(add_o), .o_data_in(din_o),
        .i_data_out(dout), .i_end_op(eop),
        .o_data_out_r(dout_r), .o_end_op_r(eop_r),
        .o_busy(busy), .o_timeout(to)
    );

    se_core_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(0)) dut_nowd (
        .i_clk(clk), .i_rst(rst),
        .i_req(b_req), .i_release('0),
        .i_control_r(b_ctl), .i_add_r('0), .i_data_in_r('0),
        .o_grant(b_grant), .o_control(b_control),
        .o_add(b_add_o), .o_data_in(b_din_o),
        .i_data_out('0), .i_end_op(1'b0),
        .o_data_out_r(b_dout_r), .o_end_op_r(b_eop_r),
        .o_busy(b_busy), .o_timeout(b_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        req = '0; rel = '0; ctl = '0; add = '0; din = '0;
        dout = '0; eop = 1'b0; b_req = '0; b_ctl = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_in();
        step();
        rst = 1'b1;
        step();
    endtask

    int  to_cnt;
    logic b_bad;

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b0;
        clear_in();
        #2;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ctl", control, 64'h0);
        chk("rst_to", 64'(to), 64'h0);
        chk("rst_eop", 64'(eop_r), 64'h0);
        step();
        rst = 1'b1;
        step();

        // single requester: mux, end_op routing, release, flush
        req = 2'b01;
        ctl[0 +: DW] = 64'd3;
        add[0 +: DW] = 64'd0;
        din[0 +: DW] = 64'd8193;
        settle();
        chk("t1_pre_grant", 64'(grant), 64'h0);
        chk("t1_pre_ctl", control, 64'h0);
        step();
        chk("t1_grant", 64'(grant), 64'h1);
        chk("t1_ctl", control, 64'd3);
        chk("t1_add", add_o, 64'd0);
        chk("t1_din", din_o, 64'd8193);
        chk("t1_busy", 64'(busy), 64'h1);
        eop = 1'b1;
        dout = 64'hABCD;
        settle();
        chk("t1_eop", 64'(eop_r), 64'h1);
        chk("t1_dout", dout_r, 64'hABCD);
        eop = 1'b0;
        rel = 2'b01;
        req = 2'b00;
        step();
        rel = '0;
        settle();
        chk("t1_fl_grant", 64'(grant), 64'h0);
        chk("t1_fl_ctl", control, 64'h0);
        chk("t1_fl_busy", 64'(busy), 64'h1);
        chk("t1_fl_dout", dout_r, 64'h0);
        step();
        chk("t1_idle_busy", 64'(busy), 64'h0);

        // two requesters, round robin
        do_reset();
        req = 2'b11;
        ctl[0 +: DW]  = 64'd5;
        ctl[DW +: DW] = 64'd7;
        add[DW +: DW] = 64'h1234;
        step();
        chk("t2_g0", 64'(grant), 64'h1);
        chk("t2_ctl0", control, 64'd5);
        rel = 2'b01;
        step();
        rel = '0;
        settle();
        chk("t2_fl_grant", 64'(grant), 64'h0);
        chk("t2_fl_ctl", control, 64'h0);
        step();
        chk("t2_g1", 64'(grant), 64'h2);
        chk("t2_ctl1", control, 64'd7);
        chk("t2_add1", add_o, 64'h1234);
        rel = 2'b10;
        step();
        rel = '0;
        settle();
        chk("t2_fl2_grant", 64'(grant), 64'h0);
        step();
        chk("t2_g0_again", 64'(grant), 64'h1);

        // watchdog expiry with TIMEOUT=16
        do_reset();
        req = 2'b11;
        ctl[0 +: DW]  = 64'd1;
        ctl[DW +: DW] = 64'd9;
        step();
        chk("t3_grant", 64'(grant), 64'h1);
        to_cnt = 0;
        if (to) to_cnt++;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (to) to_cnt++;
        end
        chk("t3_to_now", 64'(to), 64'h1);
        chk("t3_to_once", 64'(to_cnt), 64'd1);
        chk("t3_to_grant", 64'(grant), 64'h1);
        step();
        chk("t3_fl_grant", 64'(grant), 64'h0);
        chk("t3_fl_to", 64'(to), 64'h0);
        step();
        chk("t3_g1", 64'(grant), 64'h2);
        chk("t3_ctl1", control, 64'd9);
        req = '0;
        step();
        step();

        // release together with end_op; non-owner release ignored
        do_reset();
        req = 2'b11;
        ctl[0 +: DW] = 64'd2;
        step();
        chk("t4_grant", 64'(grant), 64'h1);
        rel = 2'b10;
        step();
        rel = '0;
        settle();
        chk("t4_nonowner_rel", 64'(grant), 64'h1);
        rel = 2'b01;
        eop = 1'b1;
        settle();
        chk("t4_eop", 64'(eop_r), 64'h1);
        step();
        rel = '0;
        settle();
        chk("t4_fl_eop", 64'(eop_r), 64'h0);
        chk("t4_fl_grant", 64'(grant), 64'h0);
        eop = 1'b0;
        step();
        chk("t4_g1", 64'(grant), 64'h2);

        // asynchronous reset mid-ownership
        do_reset();
        req = 2'b11;
        ctl[0 +: DW] = 64'd6;
        step();
        chk("t5_grant", 64'(grant), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_grant", 64'(grant), 64'h0);
        chk("t5_rst_ctl", control, 64'h0);
        chk("t5_rst_busy", 64'(busy), 64'h0);
        #2;
        rst = 1'b1;
        step();
        chk("t5_regrant", 64'(grant), 64'h1);
        req = '0;

        // watchdog disabled: grant held for 5000 busy cycles
        do_reset();
        b_req = 2'b01;
        b_ctl[0 +: DW] = 64'd4;
        step();
        chk("t6_grant", 64'(b_grant), 64'h1);
        b_bad = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (b_to || b_grant != 2'b01) b_bad = 1'b1;
        end
        chk("t6_no_timeout", 64'(b_bad), 64'h0);
        chk("t6_ctl", b_control, 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
